// File: rtl/aes_pkg.sv
// Shared AES types, round counts and GF(2^8) state transforms.
// Used by both the encipher and decipher datapaths.
package aes_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } ctrl_t;

  typedef enum logic [2:0] {
    NO_UPDATE    = 3'd0,
    INIT_UPDATE  = 3'd1,
    SBOX_UPDATE  = 3'd2,
    MAIN_UPDATE  = 3'd3,
    FINAL_UPDATE = 3'd4
  } update_t;

  function automatic logic [7:0] gm2(
    input logic [7:0] op
  );
    return {op[6:0], 1'b0} ^
           (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm3(
    input logic [7:0] op
  );
    return gm2(op) ^ op;
  endfunction

  function automatic logic [31:0] mixw(
    input logic [31:0] w
  );
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    m0 = gm2(b0) ^ gm3(b1) ^ b2 ^ b3;
    m1 = b0 ^ gm2(b1) ^ gm3(b2) ^ b3;
    m2 = b0 ^ b1 ^ gm2(b2) ^ gm3(b3);
    m3 = gm3(b0) ^ b1 ^ b2 ^ gm2(b3);
    return {m0, m1, m2, m3};
  endfunction

  function automatic logic [127:0] mixcolumns(
    input logic [127:0] data
  );
    return {mixw(data[127:96]),
            mixw(data[95:64]),
            mixw(data[63:32]),
            mixw(data[31:0])};
  endfunction

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shiftrows(
    input logic [127:0] data
  );
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] s0, s1, s2, s3;
    w0 = data[127:96];
    w1 = data[95:64];
    w2 = data[63:32];
    w3 = data[31:0];
    s0 = {w0[31:24], w1[23:16],
          w2[15:8],  w3[7:0]};
    s1 = {w1[31:24], w2[23:16],
          w3[15:8],  w0[7:0]};
    s2 = {w2[31:24], w3[23:16],
          w0[15:8],  w1[7:0]};
    s3 = {w3[31:24], w0[23:16],
          w1[15:8],  w2[7:0]};
    return {s0, s1, s2, s3};
  endfunction

  function automatic logic [127:0] addroundkey(
    input logic [127:0] data,
    input logic [127:0] rkey
  );
    return data ^ rkey;
  endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Bus between the encipher datapath and the core:
// start/result handshake, key memory lookup and shared sbox.
interface aes_encipher_block_if;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next,
    output keylen,
    output round_key,
    output new_sboxw,
    output block,
    input  round,
    input  sboxw,
    input  new_block,
    input  ready
  );

  modport slave (
    input  next,
    input  keylen,
    input  round_key,
    input  new_sboxw,
    input  block,
    output round,
    output sboxw,
    output new_block,
    output ready
  );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath; SubBytes one word per
// cycle through the core's shared sbox.
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic clk,
  input  logic reset,
  aes_encipher_block_if.slave bus
);

  ctrl_t       ctrl_reg;
  ctrl_t       ctrl_new;
  update_t     update_type;

  logic [31:0] w_reg [4];
  logic [3:0]  w_we;
  logic [127:0] upd;
  logic [127:0] state;

  logic [1:0]  sword_ctr_reg;
  logic        sword_rst;
  logic        sword_inc;

  logic [3:0]  round_ctr_reg;
  logic        round_rst;
  logic        round_inc;

  logic        keylen_reg;
  logic        keylen_we;

  logic        ready_reg;
  logic        ready_new;
  logic        ready_we;

  logic [3:0]  num_rounds;
  logic        last_round;
  logic [31:0] sboxw_int;

  assign state = {w_reg[0], w_reg[1],
                  w_reg[2], w_reg[3]};

  assign num_rounds = keylen_reg ?
                      AES256_ROUNDS :
                      AES128_ROUNDS;

  assign last_round =
    (round_ctr_reg >= num_rounds);

  assign bus.round     = round_ctr_reg;
  assign bus.sboxw     = sboxw_int;
  assign bus.new_block = state;
  assign bus.ready     = ready_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg <= CTRL_IDLE;
    end else begin
      ctrl_reg <= ctrl_new;
    end
  end

  always_comb begin
    ctrl_new = ctrl_reg;
    unique case (ctrl_reg)
      CTRL_IDLE: begin
        if (bus.next) begin
          ctrl_new = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        ctrl_new = CTRL_SBOX;
      end
      CTRL_SBOX: begin
        if (sword_ctr_reg == 2'd3) begin
          ctrl_new = CTRL_MAIN;
        end
      end
      CTRL_MAIN: begin
        if (last_round) begin
          ctrl_new = CTRL_IDLE;
        end else begin
          ctrl_new = CTRL_SBOX;
        end
      end
      default: begin
        ctrl_new = CTRL_IDLE;
      end
    endcase
  end

  always_comb begin
    update_type = NO_UPDATE;
    round_rst   = 1'b0;
    round_inc   = 1'b0;
    sword_rst   = 1'b0;
    sword_inc   = 1'b0;
    keylen_we   = 1'b0;
    ready_new   = 1'b0;
    ready_we    = 1'b0;
    sboxw_int   = '0;
    unique case (ctrl_reg)
      CTRL_IDLE: begin
        if (bus.next) begin
          round_rst = 1'b1;
          keylen_we = 1'b1;
          ready_we  = 1'b1;
        end
      end
      CTRL_INIT: begin
        update_type = INIT_UPDATE;
        round_inc   = 1'b1;
        sword_rst   = 1'b1;
      end
      CTRL_SBOX: begin
        update_type = SBOX_UPDATE;
        sword_inc   = 1'b1;
        sboxw_int   = w_reg[sword_ctr_reg];
      end
      CTRL_MAIN: begin
        sword_rst = 1'b1;
        if (last_round) begin
          update_type = FINAL_UPDATE;
          ready_new   = 1'b1;
          ready_we    = 1'b1;
        end else begin
          update_type = MAIN_UPDATE;
          round_inc   = 1'b1;
        end
      end
      default: begin
        update_type = NO_UPDATE;
      end
    endcase
  end

  // SBOX broadcasts the substituted word; the
  // write enable picks the single target word.
  always_comb begin
    upd  = '0;
    w_we = '0;
    unique case (update_type)
      INIT_UPDATE: begin
        upd  = addroundkey(bus.block,
                           bus.round_key);
        w_we = 4'hf;
      end
      SBOX_UPDATE: begin
        upd = {4{bus.new_sboxw}};
        w_we[sword_ctr_reg] = 1'b1;
      end
      MAIN_UPDATE: begin
        upd  = addroundkey(
                 mixcolumns(shiftrows(state)),
                 bus.round_key);
        w_we = 4'hf;
      end
      FINAL_UPDATE: begin
        upd  = addroundkey(shiftrows(state),
                           bus.round_key);
        w_we = 4'hf;
      end
      default: begin
        upd  = '0;
        w_we = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        w_reg[i] <= '0;
      end
      sword_ctr_reg <= '0;
      round_ctr_reg <= '0;
      keylen_reg    <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) begin
          w_reg[i] <= upd[127-32*i -: 32];
        end
      end
      if (sword_rst) begin
        sword_ctr_reg <= '0;
      end else if (sword_inc) begin
        sword_ctr_reg <= sword_ctr_reg + 2'd1;
      end
      if (round_rst) begin
        round_ctr_reg <= '0;
      end else if (round_inc) begin
        round_ctr_reg <= round_ctr_reg + 4'd1;
      end
      if (keylen_we) begin
        keylen_reg <= bus.keylen;
      end
      if (ready_we) begin
        ready_reg <= ready_new;
      end
    end
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: byte-level AES model,
// sbox and key memory models, FIPS-197 and random vectors.
module tb_aes_encipher_block;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_encipher_block_if bus();

  aes_encipher_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_mem [16];

  assign bus.new_sboxw = {sbox_t[bus.sboxw[31:24]],
                          sbox_t[bus.sboxw[23:16]],
                          sbox_t[bus.sboxw[15:8]],
                          sbox_t[bus.sboxw[7:0]]};
  assign bus.round_key = rk_mem[bus.round];

  int n_chk = 0;
  int n_fail = 0;

  int           lat_obs;
  int           sbox_viol;
  logic         drop_ok;
  logic [127:0] ct_obs;
  logic [3:0]   rseq [$];

  typedef struct {
    string        name;
    logic [255:0] key;
    logic         kl;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs [3];

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]],
            sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input logic kl);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    for (int r = 0; r <= nr; r++)
      rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Byte-array cipher: s[r + 4*c] holds row r, column c.
  function automatic logic [127:0] ref_encrypt(
    input logic [127:0] pt,
    input int nr
  );
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    logic [127:0] k;
    k = rk_mem[0];
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd < nr)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^
                       gmul(8'h03, t[4*c+(r+1)%4]) ^
                       t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      k = rk_mem[rd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(
    input string name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts an operation and samples every cycle until ready returns.
  task automatic run_op(
    input logic [127:0] pt,
    input logic kl,
    input bit hold,
    input int busy_at
  );
    bit in_sbox;
    bus.block = pt;
    bus.keylen = kl;
    bus.next = 1'b1;
    lat_obs = 0;
    sbox_viol = 0;
    drop_ok = 1'b0;
    rseq.delete();
    forever begin
      @(posedge clk);
      #1;
      lat_obs++;
      if (lat_obs == busy_at) begin
        bus.next = 1'b1;
        bus.keylen = ~bus.keylen;
      end else if (!hold) begin
        bus.next = 1'b0;
      end
      if (lat_obs == 1) drop_ok = !bus.ready;
      in_sbox = !bus.ready && lat_obs > 1 && ((lat_obs - 2) % 5) < 4;
      if (!in_sbox && bus.sboxw != 32'h0) sbox_viol++;
      if (rseq.size() == 0 || rseq[$] != bus.round)
        rseq.push_back(bus.round);
      if (bus.ready || lat_obs >= 300) break;
    end
    ct_obs = bus.new_block;
  endtask

  task automatic check_run(
    input string name,
    input logic [127:0] exp_ct,
    input int nr
  );
    int seq_err;
    chk({name, "_ct"}, ct_obs, exp_ct);
    chk({name, "_latency"}, lat_obs, 2 + 5*nr);
    chk({name, "_sboxw_idle"}, sbox_viol, 0);
    chk({name, "_ready_drop"}, drop_ok, 1);
    seq_err = (rseq.size() != nr + 1) ? 1 : 0;
    for (int i = 0; i < rseq.size(); i++)
      if (int'(rseq[i]) != i) seq_err++;
    chk({name, "_round_seq"}, seq_err, 0);
  endtask

  initial begin
    logic [255:0] rkey;
    logic [127:0] rpt;
    logic         rkl;
    logic [7:0]   inv;
    int           nr;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(a[7:0], c[7:0]) == 8'h01) inv = c[7:0];
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;

    vecs[0] = '{"fips_b", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 52};
    vecs[1] = '{"fips_c1", {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 52};
    vecs[2] = '{"fips_c3",
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                1'b1, 128'h00112233445566778899aabbccddeeff,
                128'h8ea2b7ca516745bfeafc49904b496089, 72};

    bus.next = 1'b0;
    bus.keylen = 1'b0;
    bus.block = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ready", bus.ready, 1);
    chk("reset_block", bus.new_block, 0);
    chk("reset_round", bus.round, 0);
    chk("reset_sboxw", bus.sboxw, 0);

    foreach (vecs[v]) begin
      nr = vecs[v].kl ? 14 : 10;
      load_key(vecs[v].key, vecs[v].kl);
      chk({vecs[v].name, "_model"}, ref_encrypt(vecs[v].pt, nr), vecs[v].ct);
      run_op(vecs[v].pt, vecs[v].kl, 1'b0, 0);
      check_run(vecs[v].name, vecs[v].ct, 2 + 5*nr == vecs[v].lat ? nr : 0);
    end

    load_key(vecs[1].key, 1'b0);
    run_op(vecs[1].pt, 1'b0, 1'b0, 20);
    check_run("busy_next", vecs[1].ct, 10);
    bus.keylen = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    bus.block = vecs[1].pt;
    bus.keylen = 1'b0;
    bus.next = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      bus.next = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_block", bus.new_block, 0);
    chk("abort_round", bus.round, 0);
    run_op(vecs[1].pt, 1'b0, 1'b0, 0);
    check_run("after_abort", vecs[1].ct, 10);

    for (int i = 0; i < 3; i++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
      rkl = i[0];
      load_key(rkey, rkl);
      run_op(rpt, rkl, 1'b1, 0);
      check_run($sformatf("b2b_%0d", i), ref_encrypt(rpt, rkl ? 14 : 10),
                rkl ? 14 : 10);
    end
    bus.next = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
      rkl = 1'($urandom_range(0, 1));
      load_key(rkey, rkl);
      run_op(rpt, rkl, 1'b0, 0);
      check_run($sformatf("rand_%0d", i), ref_encrypt(rpt, rkl ? 14 : 10),
                rkl ? 14 : 10);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
